multicycle_control: RTL and testbench
=====================================

Name: multicycle_control

Overview:
- Moore-style main control FSM for the multi-cycle MIPS processor.
- Sequences a shared-memory datapath (single memory, one ALU, IR/A/B/ALUOut holding registers) over FETCH/DECODE/EXECUTE/MEM/WB steps.
- Supports variable-latency memory through a ready handshake and a wait-timeout watchdog.
- Sits between the instruction register opcode field and the datapath mux/enable controls.

Parameters:
- WAIT_TIMEOUT, 16, max cycles a memory state waits for mem_ready before aborting; 0 disables the watchdog.
- CNT_W, 32, width of the performance counters.

Ports:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-low reset
- opcode  in  6  IR[31:26]
- zero  in  1  ALU zero flag
- mem_ready  in  1  memory completes the current access this cycle
- pc_en  out  1  PC load enable = PCWrite | (Branch & zero)
- IorD  out  1  memory address select: 0=PC, 1=ALUOut
- MemRead  out  1  memory read request
- MemWrite  out  1  memory write request
- IRWrite  out  1  instruction register load
- RegDst  out  1  write register select: 1=rd, 0=rt
- MemtoReg  out  1  write-back select: 1=MDR, 0=ALUOut
- RegWrite  out  1  register file write
- ALUSrcA  out  1  ALU A select: 0=PC, 1=A
- ALUSrcB  out  2  ALU B select: 00=B, 01=4, 10=SignExt, 11=SignExt<<2
- ALUOp  out  2  00=add, 01=sub, 10=funct
- PCSource  out  2  00=ALU, 01=ALUOut, 10=jump target
- state_o  out  4  current state (debug)
- instr_done  out  1  one-cycle pulse on the last cycle of each instruction
- illegal_op  out  1  one-cycle pulse when DECODE sees an unsupported opcode
- mem_timeout  out  1  one-cycle pulse when the watchdog fires
- cycle_count  out  CNT_W  performance counter
- instr_count  out  CNT_W  performance counter

Behaviour:
- Reset: state=FETCH, all outputs 0 while rst=0. First cycle after release, FETCH drives MemRead=1.
- Reset asserted mid-instruction: abort immediately (async); no partial writes after assertion.
- States and outputs; transitions occur on rising clk:
  - FETCH: IorD=0, MemRead=1, ALUSrcA=0, ALUSrcB=01, ALUOp=00, PCSource=00. IRWrite=pc_en=1 only when mem_ready=1. Goes to DECODE when mem_ready=1, else holds.
  - DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=00. Next state by opcode:
    - 000000 → RTYPE_EX
    - 100011 or 101011 → MEMADR
    - 000100 → BEQ
    - 001000 → ADDI_EX
    - 000010 → JUMP
    - any other opcode → FETCH with illegal_op=1 and instr_done=1 (treated as NOP).
  - MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to MEMRD for lw, MEMWR for sw; opcode is held stable by IR.
  - MEMRD: IorD=1, MemRead=1. Goes to MEMWB on mem_ready=1, else holds.
  - MEMWB: RegWrite=1, RegDst=0, MemtoReg=1, instr_done=1. Goes to FETCH.
  - MEMWR: IorD=1, MemWrite=1. Goes to FETCH on mem_ready=1 with instr_done=1, else holds.
  - RTYPE_EX: ALUSrcA=1, ALUSrcB=00, ALUOp=10. Goes to RTYPE_WB.
  - RTYPE_WB: RegWrite=1, RegDst=1, MemtoReg=0, instr_done=1. Goes to FETCH.
  - ADDI_EX: ALUSrcA=1, ALUSrcB=10, ALUOp=00. Goes to ADDI_WB.
  - ADDI_WB: RegWrite=1, RegDst=0, MemtoReg=0, instr_done=1. Goes to FETCH.
  - BEQ: ALUSrcA=1, ALUSrcB=00, ALUOp=01, PCSource=01, Branch internal=1 (pc_en=zero), instr_done=1. Goes to FETCH.
  - JUMP: PCSource=10, pc_en=1, instr_done=1. Goes to FETCH.
- Latency with zero wait states: R/addi/sw 4 cycles, lw 5, beq/j 3, illegal 2.
- Each mem_ready=0 cycle in FETCH/MEMRD/MEMWR adds one cycle.
- mem_ready is ignored outside memory states.
- Watchdog (WAIT_TIMEOUT>0):
  - Counter clears on entry to each memory state and counts cycles with mem_ready=0.
  - When the count reaches WAIT_TIMEOUT: pulse mem_timeout, force FETCH on the next edge, and issue no IRWrite/pc_en/RegWrite.
  - A timeout in FETCH retries the same PC.
  - mem_ready=1 on the timeout cycle wins: normal completion, no pulse.
- State encoding: 4-bit binary, held in a register. Unreachable encodings go to FETCH.

Optional Feature:
- Macro: MC_PERF_COUNTERS_EN.
- Defined:
  - cycle_count increments every cycle after reset release.
  - instr_count increments on each instr_done, including illegal NOPs.
  - Both wrap modulo 2^CNT_W and reset to 0.
- Undefined: both ports are driven constant 0 and no counter flops are built.

Decomposition:
- Package mc_pkg: state enum/localparams (FETCH..JUMP), opcode constants (OP_RTYPE, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J), ALUSrcB/PCSource/ALUOp encodings.
- Sub-module mc_wait_timer: clear/count/expired watchdog counter, parameterized by WAIT_TIMEOUT.

Test Plan:
- Reset then opcode=000000, mem_ready=1 → states FETCH,DECODE,RTYPE_EX,RTYPE_WB; RegWrite=1, RegDst=1 in cycle 4; instr_done pulses once.
- lw with mem_ready low 3 cycles in MEMRD → 8 total cycles; MemRead/IorD held stable throughout; RegWrite only in MEMWB.
- beq with zero=1 → pc_en=1, PCSource=01 in cycle 3; with zero=0 → pc_en=0, back to FETCH.
- opcode=111111 → illegal_op and instr_done pulse in DECODE, next state FETCH, no RegWrite/MemWrite.
- WAIT_TIMEOUT=4, mem_ready held 0 in MEMWR → mem_timeout after 4 waiting cycles, FETCH next, MemWrite deasserted.
- rst low during ADDI_EX → all outputs 0 immediately; after release FETCH with MemRead=1; counters at 0 (MC_PERF_COUNTERS_EN).

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and encodings for the multi-cycle MIPS control FSM.
// State, opcode, mux-select encodings and the control-word bundle.
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    MEMADR   = 4'd2,
    MEMRD    = 4'd3,
    MEMWB    = 4'd4,
    MEMWR    = 4'd5,
    RTYPE_EX = 4'd6,
    RTYPE_WB = 4'd7,
    ADDI_EX  = 4'd8,
    ADDI_WB  = 4'd9,
    BEQ      = 4'd10,
    JUMP     = 4'd11
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [1:0] SRCB_B   = 2'b00;
  localparam logic [1:0] SRCB_4   = 2'b01;
  localparam logic [1:0] SRCB_IMM = 2'b10;
  localparam logic [1:0] SRCB_BR  = 2'b11;

  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_FUNCT = 2'b10;

  localparam logic [1:0] PC_ALU = 2'b00;
  localparam logic [1:0] PC_OUT = 2'b01;
  localparam logic [1:0] PC_JMP = 2'b10;

  typedef struct packed {
    logic       pc_write;
    logic       branch;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       reg_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] pc_source;
    logic       instr_done;
    logic       illegal_op;
  } ctrl_t;

endpackage

// File: rtl/mc_wait_timer.sv
// Memory wait watchdog: counts stalled cycles, flags expiry.
// WAIT_TIMEOUT of 0 keeps expired low permanently.
module mc_wait_timer #(
  parameter int WAIT_TIMEOUT = 16
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clear,
  input  logic count,
  output logic expired
);

  localparam int W =
    (WAIT_TIMEOUT > 0) ? $clog2(WAIT_TIMEOUT + 1) : 1;

  logic [W-1:0] cnt;

  assign expired = (WAIT_TIMEOUT != 0) &&
                   (cnt == W'(WAIT_TIMEOUT));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (clear) begin
      cnt <= '0;
    end else if (count && !expired) begin
      cnt <= cnt + W'(1);
    end
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle MIPS main control FSM with memory-ready handshake.
// MC_PERF_COUNTERS_EN builds the cycle/instruction counters.
module multicycle_control
  import mc_pkg::*;
#(
  parameter int WAIT_TIMEOUT = 16,
  parameter int CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic             zero,
  input  logic             mem_ready,
  output logic             pc_en,
  output logic             IorD,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             MemtoReg,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [1:0]       ALUOp,
  output logic [1:0]       PCSource,
  output logic [3:0]       state_o,
  output logic             instr_done,
  output logic             illegal_op,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count
);

  state_t state, state_nx;
  ctrl_t  c, o;
  logic   in_mem, expired, timeout, waiting;

  assign in_mem  = state inside {FETCH, MEMRD, MEMWR};
  assign timeout = in_mem & ~mem_ready & expired;
  assign waiting = in_mem & ~mem_ready & ~expired;

  // Any cycle that is not a stall ends the wait episode.
  mc_wait_timer #(
    .WAIT_TIMEOUT(WAIT_TIMEOUT)
  ) u_timer (
    .clk    (clk),
    .rst_n  (rst),
    .clear  (~waiting),
    .count  (waiting),
    .expired(expired)
  );

  always_comb begin
    c        = '0;
    state_nx = state;
    case (state)
      FETCH: begin
        c.mem_read  = 1'b1;
        c.alu_src_b = SRCB_4;
        c.alu_op    = ALU_ADD;
        c.pc_source = PC_ALU;
        if (mem_ready) begin
          c.ir_write = 1'b1;
          c.pc_write = 1'b1;
          state_nx   = DECODE;
        end
      end
      DECODE: begin
        c.alu_src_b = SRCB_BR;
        unique case (1'b1)
          (opcode == OP_RTYPE): state_nx = RTYPE_EX;
          (opcode == OP_LW),
          (opcode == OP_SW):    state_nx = MEMADR;
          (opcode == OP_BEQ):   state_nx = BEQ;
          (opcode == OP_ADDI):  state_nx = ADDI_EX;
          (opcode == OP_J):     state_nx = JUMP;
          default: begin
            c.illegal_op = 1'b1;
            c.instr_done = 1'b1;
            state_nx     = FETCH;
          end
        endcase
      end
      MEMADR: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_nx = (opcode == OP_SW) ? MEMWR : MEMRD;
      end
      MEMRD: begin
        c.iord     = 1'b1;
        c.mem_read = 1'b1;
        if (mem_ready)    state_nx = MEMWB;
        else if (timeout) state_nx = FETCH;
      end
      MEMWB: begin
        c.reg_write  = 1'b1;
        c.mem_to_reg = 1'b1;
        c.instr_done = 1'b1;
        state_nx     = FETCH;
      end
      MEMWR: begin
        c.iord      = 1'b1;
        c.mem_write = 1'b1;
        if (mem_ready) begin
          c.instr_done = 1'b1;
          state_nx     = FETCH;
        end else if (timeout) begin
          state_nx = FETCH;
        end
      end
      RTYPE_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_B;
        c.alu_op    = ALU_FUNCT;
        state_nx    = RTYPE_WB;
      end
      RTYPE_WB: begin
        c.reg_write  = 1'b1;
        c.reg_dst    = 1'b1;
        c.instr_done = 1'b1;
        state_nx     = FETCH;
      end
      ADDI_EX: begin
        c.alu_src_a = 1'b1;
        c.alu_src_b = SRCB_IMM;
        state_nx    = ADDI_WB;
      end
      ADDI_WB: begin
        c.reg_write  = 1'b1;
        c.instr_done = 1'b1;
        state_nx     = FETCH;
      end
      BEQ: begin
        c.alu_src_a  = 1'b1;
        c.alu_src_b  = SRCB_B;
        c.alu_op     = ALU_SUB;
        c.pc_source  = PC_OUT;
        c.branch     = 1'b1;
        c.instr_done = 1'b1;
        state_nx     = FETCH;
      end
      JUMP: begin
        c.pc_source  = PC_JMP;
        c.pc_write   = 1'b1;
        c.instr_done = 1'b1;
        state_nx     = FETCH;
      end
      default: state_nx = FETCH;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= FETCH;
    else      state <= state_nx;
  end

  // Reset forces every control quiet at once, not at the next edge.
  assign o = rst ? c : '0;

  assign pc_en       = o.pc_write | (o.branch & zero);
  assign IorD        = o.iord;
  assign MemRead     = o.mem_read;
  assign MemWrite    = o.mem_write;
  assign IRWrite     = o.ir_write;
  assign RegDst      = o.reg_dst;
  assign MemtoReg    = o.mem_to_reg;
  assign RegWrite    = o.reg_write;
  assign ALUSrcA     = o.alu_src_a;
  assign ALUSrcB     = o.alu_src_b;
  assign ALUOp       = o.alu_op;
  assign PCSource    = o.pc_source;
  assign instr_done  = o.instr_done;
  assign illegal_op  = o.illegal_op;
  assign mem_timeout = rst & timeout;
  assign state_o     = state;

`ifdef MC_PERF_COUNTERS_EN
  logic [CNT_W-1:0] cyc_q, ins_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cyc_q <= '0;
      ins_q <= '0;
    end else begin
      cyc_q <= cyc_q + CNT_W'(1);
      if (o.instr_done) ins_q <= ins_q + CNT_W'(1);
    end
  end

  assign cycle_count = cyc_q;
  assign instr_count = ins_q;
`else
  assign cycle_count = '0;
  assign instr_count = '0;
`endif

endmodule

// File: tb/tb_multicycle_control.sv
// Directed bench for multicycle_control (WAIT_TIMEOUT=4).
// Counter expectations follow MC_PERF_COUNTERS_EN.
module tb_multicycle_control;

  logic        clk, rst, zero, mem_ready;
  logic [5:0]  opcode;
  logic        pc_en, IorD, MemRead, MemWrite, IRWrite;
  logic        RegDst, MemtoReg, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, ALUOp, PCSource;
  logic [3:0]  state_o;
  logic        instr_done, illegal_op, mem_timeout;
  logic [31:0] cycle_count, instr_count;
  logic [21:0] outs;

  int checks = 0;
  int errors = 0;

  multicycle_control #(
    .WAIT_TIMEOUT(4),
    .CNT_W       (32)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .pc_en      (pc_en),
    .IorD       (IorD),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .IRWrite    (IRWrite),
    .RegDst     (RegDst),
    .MemtoReg   (MemtoReg),
    .RegWrite   (RegWrite),
    .ALUSrcA    (ALUSrcA),
    .ALUSrcB    (ALUSrcB),
    .ALUOp      (ALUOp),
    .PCSource   (PCSource),
    .state_o    (state_o),
    .instr_done (instr_done),
    .illegal_op (illegal_op),
    .mem_timeout(mem_timeout),
    .cycle_count(cycle_count),
    .instr_count(instr_count)
  );

  assign outs = {pc_en, IorD, MemRead, MemWrite, IRWrite,
                 RegDst, MemtoReg, RegWrite, ALUSrcA,
                 ALUSrcB, ALUOp, PCSource, state_o,
                 instr_done, illegal_op, mem_timeout};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL sim_timeout: bench did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b0; mem_ready = 1'b0;
    opcode = 6'd0; zero = 1'b0;
    tick(); tick();
    @(negedge clk);
    checks++;
    if (outs !== 22'd0) begin
      errors++;
      $display("FAIL reset_outs: got %h expected 0", outs);
    end
    checks++;
    if (cycle_count !== 0 || instr_count !== 0) begin
      errors++;
      $display("FAIL reset_cnt: got %0d/%0d expected 0/0",
               cycle_count, instr_count);
    end
    tick();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0 || MemRead !== 1'b1 ||
        ALUSrcB !== 2'b01 || IRWrite !== 1'b0 ||
        pc_en !== 1'b0) begin
      errors++;
      $display("FAIL reset_fetch: got st=%0d mr=%b srcb=%b ir=%b",
               state_o, MemRead, ALUSrcB, IRWrite);
    end
    tick();
  endtask

  task automatic test_rtype();
    logic [3:0] exp_st [4];
    int dones = 0;
    exp_st = '{4'd0, 4'd1, 4'd6, 4'd7};
    opcode = 6'b000000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (state_o !== exp_st[i]) begin
        errors++;
        $display("FAIL rtype_state[%0d]: got %0d expected %0d",
                 i, state_o, exp_st[i]);
      end
      checks++;
      if (RegWrite !== (i == 3)) begin
        errors++;
        $display("FAIL rtype_regwrite[%0d]: got %b", i, RegWrite);
      end
      if (i == 0) begin
        checks++;
        if (IRWrite !== 1'b1 || pc_en !== 1'b1) begin
          errors++;
          $display("FAIL rtype_fetch: got ir=%b pc=%b expected 1/1",
                   IRWrite, pc_en);
        end
      end
      if (i == 2) begin
        checks++;
        if (ALUSrcA !== 1'b1 || ALUSrcB !== 2'b00 ||
            ALUOp !== 2'b10) begin
          errors++;
          $display("FAIL rtype_ex: got a=%b b=%b op=%b",
                   ALUSrcA, ALUSrcB, ALUOp);
        end
      end
      if (i == 3) begin
        checks++;
        if (RegDst !== 1'b1 || MemtoReg !== 1'b0) begin
          errors++;
          $display("FAIL rtype_wb: got dst=%b m2r=%b expected 1/0",
                   RegDst, MemtoReg);
        end
      end
      dones += int'(instr_done);
      tick();
    end
    checks++;
    if (dones != 1) begin
      errors++;
      $display("FAIL rtype_done_pulses: got %0d expected 1", dones);
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL rtype_end: got %0d expected 0", state_o);
    end
    tick();
  endtask

  task automatic test_lw_wait();
    logic [3:0] exp_st [8];
    logic       rdy    [8];
    exp_st = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd3, 4'd3, 4'd3, 4'd4};
    rdy    = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    opcode = 6'b100011;
    for (int i = 0; i < 8; i++) begin
      mem_ready = rdy[i];
      @(negedge clk);
      checks++;
      if (state_o !== exp_st[i]) begin
        errors++;
        $display("FAIL lw_state[%0d]: got %0d expected %0d",
                 i, state_o, exp_st[i]);
      end
      checks++;
      if (RegWrite !== (i == 7)) begin
        errors++;
        $display("FAIL lw_regwrite[%0d]: got %b", i, RegWrite);
      end
      if (i >= 3 && i <= 6) begin
        checks++;
        if (MemRead !== 1'b1 || IorD !== 1'b1 ||
            mem_timeout !== 1'b0) begin
          errors++;
          $display("FAIL lw_memrd[%0d]: got mr=%b iord=%b to=%b",
                   i, MemRead, IorD, mem_timeout);
        end
      end
      if (i == 7) begin
        checks++;
        if (MemtoReg !== 1'b1 || RegDst !== 1'b0 ||
            instr_done !== 1'b1) begin
          errors++;
          $display("FAIL lw_wb: got m2r=%b dst=%b done=%b",
                   MemtoReg, RegDst, instr_done);
        end
      end
      tick();
    end
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL lw_end: got %0d expected 0", state_o);
    end
    tick();
  endtask

  task automatic test_beq();
    logic [1:0] z = 2'b01;
    opcode = 6'b000100;
    for (int k = 0; k < 2; k++) begin
      zero = z[k];
      mem_ready = 1'b1;
      tick(); tick();
      @(negedge clk);
      checks++;
      if (state_o !== 4'd10 || pc_en !== z[k] ||
          PCSource !== 2'b01 || ALUOp !== 2'b01 ||
          instr_done !== 1'b1) begin
        errors++;
        $display("FAIL beq_z%0d: got st=%0d pc=%b src=%b op=%b",
                 z[k], state_o, pc_en, PCSource, ALUOp);
      end
      tick();
      mem_ready = 1'b0;
      @(negedge clk);
      checks++;
      if (state_o !== 4'd0 || pc_en !== 1'b0) begin
        errors++;
        $display("FAIL beq_end_z%0d: got st=%0d pc=%b",
                 z[k], state_o, pc_en);
      end
      tick();
    end
    zero = 1'b0;
  endtask

  task automatic test_illegal();
    opcode = 6'b111111; mem_ready = 1'b1;
    tick();
    @(negedge clk);
    checks++;
    if (state_o !== 4'd1 || illegal_op !== 1'b1 ||
        instr_done !== 1'b1 || RegWrite !== 1'b0 ||
        MemWrite !== 1'b0) begin
      errors++;
      $display("FAIL illegal_decode: got st=%0d ill=%b done=%b",
               state_o, illegal_op, instr_done);
    end
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0 || illegal_op !== 1'b0) begin
      errors++;
      $display("FAIL illegal_end: got st=%0d ill=%b",
               state_o, illegal_op);
    end
    tick();
  endtask

  task automatic test_timeout();
    opcode = 6'b101011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      checks++;
      if (state_o !== 4'd5 || MemWrite !== 1'b1 ||
          mem_timeout !== (i == 4) || instr_done !== 1'b0) begin
        errors++;
        $display("FAIL sw_wait[%0d]: got st=%0d mw=%b to=%b",
                 i, state_o, MemWrite, mem_timeout);
      end
      tick();
    end
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      checks++;
      if (state_o !== 4'd0 || MemWrite !== 1'b0 ||
          mem_timeout !== (i == 4) || IRWrite !== 1'b0 ||
          pc_en !== 1'b0) begin
        errors++;
        $display("FAIL fetch_wait[%0d]: got st=%0d mw=%b to=%b",
                 i, state_o, MemWrite, mem_timeout);
      end
      tick();
    end
  endtask

  task automatic test_ready_wins();
    opcode = 6'b101011; mem_ready = 1'b1;
    tick(); tick(); tick();
    mem_ready = 1'b0;
    tick(); tick(); tick(); tick();
    mem_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd5 || mem_timeout !== 1'b0 ||
        instr_done !== 1'b1) begin
      errors++;
      $display("FAIL sw_ready_wins: got st=%0d to=%b done=%b",
               state_o, mem_timeout, instr_done);
    end
    tick();
    mem_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (state_o !== 4'd0) begin
      errors++;
      $display("FAIL sw_end: got %0d expected 0", state_o);
    end
    tick();
  endtask

  task automatic test_addi_reset();
    logic [31:0] cc_exp, ic_exp;
    opcode = 6'b001000; mem_ready = 1'b1;
    tick(); tick(); tick();
    @(negedge clk);
    checks++;
    if (state_o !== 4'd9 || RegWrite !== 1'b1 ||
        RegDst !== 1'b0 || MemtoReg !== 1'b0) begin
      errors++;
      $display("FAIL addi_wb: got st=%0d rw=%b dst=%b m2r=%b",
               state_o, RegWrite, RegDst, MemtoReg);
    end
    tick(); tick(); tick();
    @(negedge clk);
    checks++;
    if (state_o !== 4'd8 || ALUSrcA !== 1'b1 ||
        ALUSrcB !== 2'b10) begin
      errors++;
      $display("FAIL addi_ex: got st=%0d a=%b b=%b",
               state_o, ALUSrcA, ALUSrcB);
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (outs !== 22'd0) begin
      errors++;
      $display("FAIL reset_mid: got %h expected 0", outs);
    end
    tick();
    checks++;
    if (RegWrite !== 1'b0 || state_o !== 4'd0) begin
      errors++;
      $display("FAIL reset_hold: got rw=%b st=%0d",
               RegWrite, state_o);
    end
    rst = 1'b1;
    opcode = 6'b000010;
    for (int i = 0; i < 4; i++) begin
`ifdef MC_PERF_COUNTERS_EN
      cc_exp = 32'(i);
      ic_exp = (i == 3) ? 32'd1 : 32'd0;
`else
      cc_exp = 32'd0;
      ic_exp = 32'd0;
`endif
      @(negedge clk);
      if (i == 0) begin
        checks++;
        if (state_o !== 4'd0 || MemRead !== 1'b1) begin
          errors++;
          $display("FAIL reset_release: got st=%0d mr=%b",
                   state_o, MemRead);
        end
      end
      if (i == 2) begin
        checks++;
        if (state_o !== 4'd11 || pc_en !== 1'b1 ||
            PCSource !== 2'b10) begin
          errors++;
          $display("FAIL jump: got st=%0d pc=%b src=%b",
                   state_o, pc_en, PCSource);
        end
      end
      checks++;
      if (cycle_count !== cc_exp || instr_count !== ic_exp) begin
        errors++;
        $display("FAIL counters[%0d]: got %0d/%0d expected %0d/%0d",
                 i, cycle_count, instr_count, cc_exp, ic_exp);
      end
      tick();
    end
  endtask

  initial begin
    test_reset();
    test_rtype();
    test_lw_wait();
    test_beq();
    test_illegal();
    test_timeout();
    test_ready_wins();
    test_addi_reset();
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
